tx_word_scheduler: RTL and testbench
====================================

TX_WORD_SCHEDULER -- requirements
Module: tx_word_scheduler

Interface
REQ-001 SHALL have parameter GAP_BITS, default 4, meaning the minimum inter-word gap counted in ce_tx ticks (1..15).
REQ-002 SHALL have parameter START_TO, default 16, meaning the clk cycles allowed from the st pulse until en_tx_word rises (2..255).
REQ-003 SHALL have port clk input 1, the single system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n input 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req input 4, per-requester transmit request, level, held until the matching done.
REQ-006 SHALL have port adr_in input 32, four 8-bit labels packed as requester i at bits [8i+7:8i].
REQ-007 SHALL have port dat_in input 92, four 23-bit data fields packed as requester i at bits [23i+22:23i].
REQ-008 SHALL have port ce_tx input 1, transmitter bit-rate enable, one clk wide.
REQ-009 SHALL have port en_tx_word input 1, transmitter busy flag, high while a 32-bit word is being shifted.
REQ-010 SHALL have port st output 1, one-clk start pulse to the transmitter.
REQ-011 SHALL have port ADR output 8, registered label presented to the transmitter.
REQ-012 SHALL have port DAT output 23, registered data presented to the transmitter.
REQ-013 SHALL have port grant output 4, one-hot owner of the current word; zero when idle.
REQ-014 SHALL have port done output 4, one-clk pulse on the grant bit when its word completes.
REQ-015 SHALL have port err output 1, one-clk pulse on start timeout.

Function
REQ-016 SHALL implement the states IDLE, LOAD, START, WAIT_BUSY, BUSY and GAP.
REQ-017 IDLE SHALL go to LOAD on any req bit high; the winner SHALL be chosen by round-robin, with the search starting after the last granted index (index 0 first after reset).
REQ-018 LOAD SHALL register ADR/DAT from the winner's slice and set grant one-hot; the next state SHALL be START.
REQ-019 START SHALL drive st=1 for exactly one clk; ADR/DAT SHALL be stable from LOAD until BUSY exits.
REQ-020 WAIT_BUSY SHALL go to BUSY when en_tx_word=1; if START_TO cycles pass with no rise, it SHALL pulse err, clear grant, give no done, not advance the round-robin pointer and go to IDLE.
REQ-021 BUSY SHALL, on en_tx_word falling to 0, pulse done[grant] and go to GAP; grant SHALL clear in the same cycle as done.
REQ-022 GAP SHALL count ce_tx ticks and go to IDLE after GAP_BITS ticks; req SHALL be ignored during GAP.
REQ-023 Requester latency: the first st pulse SHALL follow a req rising in IDLE by exactly 2 clks (IDLE->LOAD->START).
REQ-024 A req that drops while its word is in flight SHALL NOT abort the word; done SHALL still pulse.
REQ-025 Simultaneous requests SHALL be served one word each in rotation; no requester waits more than 3 other words.
REQ-026 The gap counter SHALL be 4 bits and SHALL saturate, not wrap.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, st=0, grant=0, done=0, err=0, ADR=0, DAT=0, gap count 0 and round-robin pointer to 3 (so index 0 wins next).
REQ-028 Reset mid-word SHALL drop st/grant at once, with no done or err issued.

Configuration
REQ-029 With macro TX_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest) and the pointer is removed; without it, round-robin per REQ-017 SHALL apply.

Verification
REQ-030 req=4'b0010, adr_in slice1=8'h88, dat_in slice1=23'h4C6600, bench model busy 32 ce_tx -> st 2 clks after req, ADR=8'h88, DAT=23'h4C6600, done=4'b0010, grant=0 after.
REQ-031 req=4'b1111 held -> grant order 0,1,2,3,0 with at least GAP_BITS=4 ce_tx ticks between en_tx_word fall and the next st.
REQ-032 req=4'b0001, en_tx_word tied 0 -> err pulse 16 clks after WAIT_BUSY entry, done=0, then st re-issued for requester 0.
REQ-033 rst_n pulled low while in BUSY -> st=0, grant=0, no done; after release, req=4'b0100 granted index 2 only.
REQ-034 TX_SCHED_FIXED_PRIO_EN defined, req=4'b1010 held -> grant always 4'b0010, never 4'b1000.
REQ-035 req[1] dropped mid-BUSY -> word completes, done[1] pulses once, scheduler returns to IDLE.

Source files
------------

// File: rtl/tx_word_scheduler.sv
// Four-requester word scheduler feeding a serial word transmitter: arbitrates, presents
// label/data, starts the transmitter and enforces an inter-word gap.
// Optional macro TX_SCHED_FIXED_PRIO_EN selects fixed priority (req[0] highest) over round-robin.
module tx_word_scheduler #(
  parameter int unsigned GAP_BITS = 4,
  parameter int unsigned START_TO = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] adr_in,
  input  logic [91:0] dat_in,
  input  logic        ce_tx,
  input  logic        en_tx_word,
  output logic        st,
  output logic [7:0]  ADR,
  output logic [22:0] DAT,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        err
);

  localparam logic [7:0] ToMax  = 8'(START_TO - 1);
  localparam logic [3:0] GapMax = 4'(GAP_BITS);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWaitBusy, StBusy, StGap} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  adr_q, adr_d;
  logic [22:0] dat_q, dat_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic        st_q, st_d;
  logic        err_q, err_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  to_q, to_d;
`ifndef TX_SCHED_FIXED_PRIO_EN
  logic [1:0]  ptr_q, ptr_d;
`endif

  logic [1:0]  win_idx;
  logic        win_vld;
  logic [7:0]  adr_sel;
  logic [22:0] dat_sel;
  logic [3:0]  gap_inc;

  assign gap_inc = (gap_q == 4'hF) ? 4'hF : gap_q + 4'd1;

  // Descending loops so the last hit (highest priority) wins.
  always_comb begin
    win_idx = 2'd0;
    win_vld = 1'b0;
`ifdef TX_SCHED_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = 2'(i);
        win_vld = 1'b1;
      end
    end
`else
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        win_idx = ptr_q + 2'(i);
        win_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    adr_sel = '0;
    dat_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (idx_q == 2'(i)) begin
        adr_sel = adr_in[8*i +: 8];
        dat_sel = dat_in[23*i +: 23];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    grant_d = grant_q;
    done_d  = 4'b0;
    st_d    = 1'b0;
    err_d   = 1'b0;
    gap_d   = gap_q;
    to_d    = to_q;
`ifndef TX_SCHED_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          idx_d   = win_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        adr_d   = adr_sel;
        dat_d   = dat_sel;
        grant_d = 4'b0001 << idx_q;
        st_d    = 1'b1;
        state_d = StStart;
      end
      StStart: begin
        to_d    = 8'd0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (en_tx_word) begin
          state_d = StBusy;
        end else if (to_q == ToMax) begin
          // Timeout leaves the pointer alone so the same requester is retried first.
          err_d   = 1'b1;
          grant_d = 4'b0;
          state_d = StIdle;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      StBusy: begin
        if (!en_tx_word) begin
          done_d  = grant_q;
          grant_d = 4'b0;
          gap_d   = 4'd0;
`ifndef TX_SCHED_FIXED_PRIO_EN
          ptr_d   = idx_q;
`endif
          state_d = StGap;
        end
      end
      StGap: begin
        if (ce_tx) begin
          gap_d = gap_inc;
          if (gap_inc >= GapMax) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= '0;
      to_q    <= '0;
`ifndef TX_SCHED_FIXED_PRIO_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      st_q    <= st_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
`ifndef TX_SCHED_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign st    = st_q;
  assign ADR   = adr_q;
  assign DAT   = dat_q;
  assign grant = grant_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_tx_word_scheduler.sv
// Directed bench for tx_word_scheduler: latency, rotation, gap, timeout, reset and req-drop cases.
module tb_tx_word_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [31:0] adr_in;
  logic [91:0] dat_in;
  logic        ce_tx = 1'b0;
  logic        en_tx_word = 1'b0;
  logic        st;
  logic [7:0]  ADR;
  logic [22:0] DAT;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_cnt   = 0;
  int hist[$];

  logic [7:0]  adr_v [4];
  logic [22:0] dat_v [4];

  tx_word_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .adr_in     (adr_in),
    .dat_in     (dat_in),
    .ce_tx      (ce_tx),
    .en_tx_word (en_tx_word),
    .st         (st),
    .ADR        (ADR),
    .DAT        (DAT),
    .grant      (grant),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Bit-rate enable every other clk, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ce_cnt++;
      ce_tx = (ce_cnt % 2 == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req        = 4'b0;
    en_tx_word = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns number of negedges until st is seen high; logs ce_tx into hist.
  task automatic wait_st(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      hist.push_back(int'(ce_tx));
      if (st) break;
      if (cyc > 200) begin
        check_eq("st_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic xmit(input int ticks);
    int n;
    n = 0;
    @(negedge clk);
    en_tx_word = 1'b1;
    while (n < ticks) begin
      @(negedge clk);
      if (ce_tx) n++;
    end
    en_tx_word = 1'b0;
  endtask

  initial begin
    int cyc;
    int k;
    int sum;
    int cnt;
    logic [3:0] exp_g;

    adr_v[0] = 8'hA1;       adr_v[1] = 8'h88;       adr_v[2] = 8'h5C;       adr_v[3] = 8'hD4;
    dat_v[0] = 23'h111111;  dat_v[1] = 23'h4C6600;  dat_v[2] = 23'h2AAAAA;  dat_v[3] = 23'h7FFFFE;
    adr_in = {adr_v[3], adr_v[2], adr_v[1], adr_v[0]};
    dat_in = {dat_v[3], dat_v[2], dat_v[1], dat_v[0]};

    // Reset values
    #2;
    check_eq("rst_st", 32'(st), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_adr", 32'(ADR), 32'd0);
    check_eq("rst_dat", 32'(DAT), 32'd0);
    do_reset();

    // Single word from requester 1
    req = 4'b0010;
    wait_st(cyc);
    check_eq("t1_latency", 32'(cyc), 32'd2);
    check_eq("t1_adr", 32'(ADR), 32'h88);
    check_eq("t1_dat", 32'(DAT), 32'h4C6600);
    check_eq("t1_grant", 32'(grant), 32'b0010);
    xmit(32);
    @(negedge clk);
    check_eq("t1_done", 32'(done), 32'b0010);
    check_eq("t1_grant_clr", 32'(grant), 32'd0);
    req = 4'b0;
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(done), 32'd0);

    // All four requesting: rotation 0,1,2,3,0 with gap enforcement
    do_reset();
    req = 4'b1111;
    hist.delete();
    for (int j = 0; j < 5; j++) begin
      wait_st(cyc);
      if (j == 0) begin
        check_eq("t2_latency", 32'(cyc), 32'd2);
      end else begin
        sum = 0;
        for (int i = 0; i < hist.size() - 3; i++) sum += hist[i];
        check_eq("t2_gap_ticks", 32'(sum), 32'd4);
      end
      exp_g = 4'b0001 << (j % 4);
      check_eq("t2_grant", 32'(grant), 32'(exp_g));
      check_eq("t2_adr", 32'(ADR), 32'(adr_v[j % 4]));
      check_eq("t2_dat", 32'(DAT), 32'(dat_v[j % 4]));
      xmit(8);
      hist.delete();
      @(negedge clk);
      hist.push_back(int'(ce_tx));
      check_eq("t2_done", 32'(done), 32'(exp_g));
      check_eq("t2_grant_clr", 32'(grant), 32'd0);
    end

    // Start timeout and retry of the same requester
    do_reset();
    req = 4'b0001;
    wait_st(cyc);
    cnt = 0;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (done != 4'b0) cnt++;
      if (err) break;
    end
    check_eq("t3_err_delay", 32'(k), 32'd17);
    check_eq("t3_no_done", 32'(cnt), 32'd0);
    check_eq("t3_grant_clr", 32'(grant), 32'd0);
    @(negedge clk);
    check_eq("t3_err_pulse", 32'(err), 32'd0);
    wait_st(cyc);
    check_eq("t3_retry_lat", 32'(cyc), 32'd1);
    check_eq("t3_retry_grant", 32'(grant), 32'b0001);
    xmit(4);
    @(negedge clk);
    check_eq("t3_done", 32'(done), 32'b0001);
    req = 4'b0;

    // Reset while busy
    do_reset();
    req = 4'b0001;
    wait_st(cyc);
    @(negedge clk);
    en_tx_word = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t4_st", 32'(st), 32'd0);
    check_eq("t4_grant", 32'(grant), 32'd0);
    check_eq("t4_done", 32'(done), 32'd0);
    en_tx_word = 1'b0;
    req = 4'b0;
    @(negedge clk);
    check_eq("t4_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    req = 4'b0100;
    wait_st(cyc);
    check_eq("t4_latency", 32'(cyc), 32'd2);
    check_eq("t4_grant2", 32'(grant), 32'b0100);
    check_eq("t4_adr", 32'(ADR), 32'(adr_v[2]));
    xmit(4);
    @(negedge clk);
    check_eq("t4_done2", 32'(done), 32'b0100);
    req = 4'b0;

    // Request dropped mid-word
    do_reset();
    req = 4'b0010;
    wait_st(cyc);
    @(negedge clk);
    en_tx_word = 1'b1;
    repeat (4) @(negedge clk);
    req = 4'b0;
    repeat (6) @(negedge clk);
    en_tx_word = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done == 4'b0010) cnt++;
      if (st || grant != 4'b0) cnt += 100;
    end
    check_eq("t5_done_once", 32'(cnt), 32'd1);
    req = 4'b0010;
    wait_st(cyc);
    check_eq("t5_idle_lat", 32'(cyc), 32'd2);
    xmit(2);
    req = 4'b0;
    @(negedge clk);
    check_eq("t5_done2", 32'(done), 32'b0010);

    // Two requesters held: fixed priority or rotation
    do_reset();
    req = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      wait_st(cyc);
`ifdef TX_SCHED_FIXED_PRIO_EN
      exp_g = 4'b0010;
`else
      exp_g = (j % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      check_eq("t6_grant", 32'(grant), 32'(exp_g));
      xmit(2);
      @(negedge clk);
      check_eq("t6_done", 32'(done), 32'(exp_g));
    end
    req = 4'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
